// File: rtl/scan_link_receiver.sv
// rtl/scan_link_receiver.sv - deserializer and command decoder for the scanner serial link
// Frames are 8 bits MSB first; command 7 is followed by one raw data byte.
module scan_link_receiver #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serClk,
  input  logic       serData,
  output logic       cmdReady,
  output logic       cmdStart,
  output logic       cmdFull,
  output logic       dataValid,
  output logic [7:0] dataByte,
  output logic [7:0] lastCmd,
  output logic       cmdError,
  output logic       frameError,
  output logic       busy
);

  typedef enum logic {CMD, DATA} state_t;

  state_t     state;
  logic       clk_meta, clk_sync, clk_prev;
  logic       data_meta, data_sync;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [7:0] tmo_cnt;
  logic       word_done;
  logic       rise;

  assign rise = clk_sync & ~clk_prev;
  // word_done keeps busy up until the decode cycle, so busy drops with the final pulse
  assign busy = (bit_cnt != 3'd0) || (state == DATA) || word_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CMD;
      clk_meta   <= 1'b0;
      clk_sync   <= 1'b0;
      clk_prev   <= 1'b0;
      data_meta  <= 1'b0;
      data_sync  <= 1'b0;
      shift_reg  <= 8'd0;
      bit_cnt    <= 3'd0;
      tmo_cnt    <= 8'd0;
      word_done  <= 1'b0;
      cmdReady   <= 1'b0;
      cmdStart   <= 1'b0;
      cmdFull    <= 1'b0;
      dataValid  <= 1'b0;
      dataByte   <= 8'd0;
      lastCmd    <= 8'd0;
      cmdError   <= 1'b0;
      frameError <= 1'b0;
    end else begin
      clk_meta   <= serClk;
      clk_sync   <= clk_meta;
      clk_prev   <= clk_sync;
      data_meta  <= serData;
      data_sync  <= data_meta;
      cmdReady   <= 1'b0;
      cmdStart   <= 1'b0;
      cmdFull    <= 1'b0;
      dataValid  <= 1'b0;
      cmdError   <= 1'b0;
      frameError <= 1'b0;
      word_done  <= 1'b0;

      // A rise wins over a timeout landing in the same cycle
      if (rise) begin
        shift_reg <= {shift_reg[6:0], data_sync};
        bit_cnt   <= bit_cnt + 3'd1;
        tmo_cnt   <= 8'd0;
        if (bit_cnt == 3'd7) word_done <= 1'b1;
      end else if (busy) begin
        if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          frameError <= 1'b1;
          bit_cnt    <= 3'd0;
          state      <= CMD;
          tmo_cnt    <= 8'd0;
          shift_reg  <= 8'd0;
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
      end else begin
        tmo_cnt <= 8'd0;
      end

      if (word_done) begin
        if (state == DATA) begin
          dataByte  <= shift_reg;
          dataValid <= 1'b1;
          state     <= CMD;
        end else begin
          lastCmd <= shift_reg;
          case (shift_reg)
            8'd2:    cmdReady <= 1'b1;
            8'd3:    cmdStart <= 1'b1;
            8'd4:    cmdFull  <= 1'b1;
            8'd7:    state    <= DATA;
            default: cmdError <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_link_receiver.sv
// tb/tb_scan_link_receiver.sv - scoreboard bench for scan_link_receiver
module tb_scan_link_receiver;

  localparam int K_READY = 1, K_START = 2, K_FULL = 3, K_DATA = 4, K_CERR = 5, K_FERR = 6;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       serClk;
  logic       serData;
  logic       cmdReady, cmdStart, cmdFull, dataValid, cmdError, frameError, busy;
  logic [7:0] dataByte, lastCmd;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  scan_link_receiver #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .serClk     (serClk),
    .serData    (serData),
    .cmdReady   (cmdReady),
    .cmdStart   (cmdStart),
    .cmdFull    (cmdFull),
    .dataValid  (dataValid),
    .dataByte   (dataByte),
    .lastCmd    (lastCmd),
    .cmdError   (cmdError),
    .frameError (frameError),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the top nbits of b MSB first; last_rise is the cycle the final rising edge was driven
  task automatic send_bits(input logic [7:0] b, input int nbits, output int last_rise);
    logic [7:0] v;
    v = b;
    last_rise = 0;
    for (int i = 0; i < nbits; i++) begin
      serData = v[7 - i];
      tick(HALF);
      serClk = 1'b1;
      last_rise = cyc;
      tick(HALF);
      serClk = 1'b0;
    end
  endtask

  task automatic send_expect(input logic [7:0] b, input int kind, input int val);
    int lr;
    send_bits(b, 8, lr);
    if (kind != 0) q.push_back('{kind: kind, val: val, cyc: lr + 4});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    tick(2);
  endtask

  logic [5:0] pulses;
  int         code;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst) begin
      pulses = {frameError, cmdError, dataValid, cmdFull, cmdStart, cmdReady};
      if (pulses != 6'd0) begin
        check("pulse_onehot", $countones(pulses), 1);
        code = cmdReady ? K_READY : cmdStart ? K_START : cmdFull ? K_FULL :
               dataValid ? K_DATA : cmdError ? K_CERR : K_FERR;
        if (q.size() == 0) begin
          check("unexpected_pulse", code, 0);
        end else begin
          e = q.pop_front();
          check("pulse_kind", code, e.kind);
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_value", (code == K_DATA) ? dataByte : lastCmd, e.val);
          check("busy_after_pulse", busy, 0);
        end
      end
    end
  end

  int lr5;

  initial begin
    rst = 1'b1;
    serClk = 1'b0;
    serData = 1'b0;
    tick(3);
    check("rst_lastCmd", lastCmd, 0);
    check("rst_dataByte", dataByte, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {cmdReady, cmdStart, cmdFull, dataValid, cmdError, frameError}, 0);
    rst = 1'b0;
    tick(2);

    send_expect(8'h03, K_START, 8'h03);
    drain();
    check("cmd3_lastCmd", lastCmd, 8'h03);
    check("cmd3_busy", busy, 0);

    send_expect(8'h07, 0, 0);
    tick(2);
    check("c7_busy_between", busy, 1);
    check("c7_lastCmd", lastCmd, 8'h07);
    send_expect(8'hA5, K_DATA, 8'hA5);
    drain();
    check("a5_lastCmd", lastCmd, 8'h07);

    send_expect(8'h07, 0, 0);
    send_expect(8'h02, K_DATA, 8'h02);
    drain();
    check("d02_dataByte", dataByte, 8'h02);

    send_expect(8'h55, K_CERR, 8'h55);
    send_expect(8'h04, K_FULL, 8'h04);
    drain();
    check("full_lastCmd", lastCmd, 8'h04);

    send_bits(8'hF0, 5, lr5);
    q.push_back('{kind: K_FERR, val: 8'h04, cyc: lr5 + 3 + 64});
    tick(2);
    check("partial_busy", busy, 1);
    tick(80);
    check("tmo_queue_empty", q.size(), 0);
    check("tmo_busy", busy, 0);
    send_expect(8'h02, K_READY, 8'h02);
    drain();

    send_expect(8'h07, 0, 0);
    send_bits(8'hC3, 4, lr5);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_lastCmd", lastCmd, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pulses", {cmdReady, cmdStart, cmdFull, dataValid, cmdError, frameError}, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    send_expect(8'h03, K_START, 8'h03);
    drain();
    check("post_rst_dataByte", dataByte, 0);
    check("final_queue", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
